// File: rtl/i2c_reg_sequencer.sv
// Purpose: sequences single-byte I2C register reads/writes through the bit-level master.
// Latency: one master command per phase; ready returns 1 cycle after the done pulse.
// Backpressure: req is taken only while ready=1; a req seen while busy is dropped, not queued.
//
// Ports:
//   clk, rst            : logic clock and synchronous active-high reset
//   req, req_read, req_dev, req_reg, req_wdata : request strobe and its fields
//   ready, done, status, rdata                 : request handshake and result
//   m_dIn, m_readNWrite, m_start, m_stop, m_sendAck : commands to the bit-level master
//   m_dOut, m_dOutStrobe, m_recvAck, m_busy         : responses from the bit-level master
module i2c_reg_sequencer #(
    parameter int ADDRESS_BITS   = 7,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic                    req_read,
    input  logic [ADDRESS_BITS-1:0] req_dev,
    input  logic [7:0]              req_reg,
    input  logic [7:0]              req_wdata,
    output logic                    ready,
    output logic                    done,
    output logic [1:0]              status,
    output logic [7:0]              rdata,
    output logic [9:0]              m_dIn,
    output logic                    m_readNWrite,
    output logic                    m_start,
    output logic                    m_stop,
    output logic                    m_sendAck,
    input  logic [7:0]              m_dOut,
    input  logic                    m_dOutStrobe,
    input  logic                    m_recvAck,
    input  logic                    m_busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_ADDR_NAK = 2'd1;
    localparam logic [1:0] ST_DATA_NAK = 2'd2;
    localparam logic [1:0] ST_TIMEOUT  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR_W,
        S_REG,
        S_WDATA,
        S_ADDR_R,
        S_RDATA,
        S_STOP,
        S_ABORT,
        S_DONE
    } state_t;

    state_t                  state, state_d;
    // 0: command presented, waiting for busy to rise; 1: waiting for busy to fall
    logic                    wait_fall, wait_fall_d;
    logic [CW-1:0]           tcnt, tcnt_d;
    logic [1:0]              status_q, status_d;
    logic [7:0]              rdata_q, rdata_d;
    logic [7:0]              shadow_q, shadow_d;
    logic                    strobe_q;
    logic                    rd_q;
    logic [ADDRESS_BITS-1:0] dev_q;
    logic [7:0]              reg_q;
    logic [7:0]              wdata_q;

    logic                    in_phase;
    logic                    timed_out;

    assign in_phase  = (state == S_ADDR_W) || (state == S_REG)   || (state == S_WDATA) ||
                       (state == S_ADDR_R) || (state == S_RDATA) || (state == S_STOP);
    assign timed_out = in_phase && (tcnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_fall <= 1'b0;
            tcnt      <= '0;
            status_q  <= ST_OK;
            rdata_q   <= 8'h00;
            shadow_q  <= 8'h00;
            strobe_q  <= 1'b0;
            rd_q      <= 1'b0;
            dev_q     <= '0;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
        end else begin
            state     <= state_d;
            wait_fall <= wait_fall_d;
            tcnt      <= tcnt_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
            shadow_q  <= shadow_d;
            strobe_q  <= m_dOutStrobe;
            if (state == S_IDLE && req) begin
                rd_q    <= req_read;
                dev_q   <= req_dev;
                reg_q   <= req_reg;
                wdata_q <= req_wdata;
            end
        end
    end

    always_comb begin
        state_d     = state;
        wait_fall_d = wait_fall;
        tcnt_d      = '0;
        status_d    = status_q;
        rdata_d     = rdata_q;
        shadow_d    = shadow_q;

        if (in_phase) begin
            tcnt_d = tcnt + CW'(1);
        end

        case (state)
            S_IDLE: begin
                if (req) begin
                    state_d  = S_ADDR_W;
                    status_d = ST_OK;
                end
            end
            S_ABORT: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: ;
        endcase

        if (in_phase) begin
            if (timed_out) begin
                // A stuck STOP still finishes the transaction, but an earlier NACK keeps its code.
                if (state == S_STOP) begin
                    state_d = S_DONE;
                    if (status_q == ST_OK) begin
                        status_d = ST_TIMEOUT;
                    end
                end else begin
                    state_d  = S_ABORT;
                    status_d = ST_TIMEOUT;
                end
            end else if (!wait_fall) begin
                if (m_busy) begin
                    wait_fall_d = 1'b1;
                end
            end else if (!m_busy) begin
                // Busy falling edge: the phase is complete and m_recvAck is valid now.
                case (state)
                    S_ADDR_W: begin
                        if (m_recvAck) begin
                            status_d = ST_ADDR_NAK;
                            state_d  = S_STOP;
                        end else begin
                            state_d = S_REG;
                        end
                    end
                    S_REG: begin
                        if (m_recvAck) begin
                            status_d = ST_DATA_NAK;
                            state_d  = S_STOP;
                        end else begin
                            state_d = rd_q ? S_ADDR_R : S_WDATA;
                        end
                    end
                    S_WDATA: begin
                        if (m_recvAck) begin
                            status_d = ST_DATA_NAK;
                        end
                        state_d = S_STOP;
                    end
                    S_ADDR_R: begin
                        if (m_recvAck) begin
                            status_d = ST_ADDR_NAK;
                            state_d  = S_STOP;
                        end else begin
                            state_d = S_RDATA;
                        end
                    end
                    S_RDATA: state_d = S_STOP;
                    S_STOP:  state_d = S_DONE;
                    default: ;
                endcase
            end
        end

        if (state == S_RDATA && m_dOutStrobe && !strobe_q) begin
            shadow_d = m_dOut;
        end

        // Every phase starts with a fresh handshake and a fresh timeout budget.
        if (state_d != state) begin
            wait_fall_d = 1'b0;
            tcnt_d      = '0;
        end

        // rdata is loaded on entry to DONE so it is already valid alongside the done pulse.
        if (state_d == S_DONE && state != S_DONE && status_d == ST_OK && rd_q) begin
            rdata_d = shadow_q;
        end
    end

    always_comb begin
        m_start      = 1'b0;
        m_stop       = 1'b0;
        m_readNWrite = 1'b0;
        m_dIn        = 10'h000;
        if (!wait_fall) begin
            case (state)
                S_ADDR_W: begin
                    m_start = 1'b1;
                    m_dIn   = 10'(dev_q);
                end
                S_REG:   m_dIn = 10'(reg_q);
                S_WDATA: m_dIn = 10'(wdata_q);
                S_ADDR_R: begin
                    m_start      = 1'b1;
                    m_readNWrite = 1'b1;
                    m_dIn        = 10'(dev_q);
                end
                S_RDATA: m_readNWrite = 1'b1;
                S_STOP:  m_stop = 1'b1;
                default: ;
            endcase
        end
    end

    // Only a single byte is ever read, so it is always NACKed.
    assign m_sendAck = 1'b0;
    assign ready     = (state == S_IDLE);
    assign done      = (state == S_DONE);
    assign status    = status_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
module tb_i2c_reg_sequencer;

    localparam int AB = 7;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req = 1'b0;
    logic          req_read = 1'b0;
    logic [AB-1:0] req_dev = '0;
    logic [7:0]    req_reg = 8'h00;
    logic [7:0]    req_wdata = 8'h00;
    logic          ready, done;
    logic [1:0]    status;
    logic [7:0]    rdata;
    logic [9:0]    m_dIn;
    logic          m_readNWrite, m_start, m_stop, m_sendAck;
    logic [7:0]    m_dOut = 8'h00;
    logic          m_dOutStrobe = 1'b0;
    logic          m_recvAck = 1'b0;
    logic          m_busy = 1'b0;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.ADDRESS_BITS(AB), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_read(req_read), .req_dev(req_dev),
        .req_reg(req_reg), .req_wdata(req_wdata), .ready(ready), .done(done),
        .status(status), .rdata(rdata), .m_dIn(m_dIn), .m_readNWrite(m_readNWrite),
        .m_start(m_start), .m_stop(m_stop), .m_sendAck(m_sendAck), .m_dOut(m_dOut),
        .m_dOutStrobe(m_dOutStrobe), .m_recvAck(m_recvAck), .m_busy(m_busy)
    );

    int vectors = 0;
    int errs = 0;

    // op = {sendAck, start, stop, readNWrite, dIn}; result = {valid, status, rdata}
    logic [13:0] exp_ops[$];
    logic [10:0] exp_done[$];

    int       hang = 0;
    int       mdl_hold = 0;
    int       nack_idx = -1;
    logic [7:0] rbyte = 8'h00;
    int       op_idx = 0;
    int       hcnt = 0;
    bit       cur_rd = 1'b0;
    int       done_cnt = 0;
    int       stop_cnt = 0;
    int       cyc = 0;
    logic [7:0] exp_rdata = 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [13:0] op(input logic s, input logic p, input logic r, input logic [9:0] d);
        return {1'b0, s, p, r, d};
    endfunction

    // Bit-level master model: takes whatever command is presented, stays busy 3 cycles.
    always begin
        logic [13:0] obs;
        logic [13:0] expv;
        @(posedge clk);
        #1;
        if (ready === 1'b1) op_idx = 0;
        if (mdl_hold != 0 || hang != 0) begin
            m_busy = 1'b0;
            m_dOutStrobe = 1'b0;
            hcnt = 0;
        end else if (!m_busy) begin
            m_dOutStrobe = 1'b0;
            if (ready === 1'b0 && done === 1'b0) begin
                obs  = {m_sendAck, m_start, m_stop, m_readNWrite, m_dIn};
                expv = (exp_ops.size() > 0) ? exp_ops.pop_front() : 14'h3fff;
                chk("master_op", 32'(obs), 32'(expv));
                cur_rd = m_readNWrite && !m_start && !m_stop;
                m_busy = 1'b1;
                m_recvAck = 1'b0;
                hcnt = 0;
            end
        end else begin
            hcnt++;
            if (cur_rd && hcnt == 1) begin
                m_dOutStrobe = 1'b1;
                m_dOut = rbyte;
            end else begin
                m_dOutStrobe = 1'b0;
            end
            if (hcnt == 3) begin
                m_busy = 1'b0;
                m_recvAck = (op_idx == nack_idx);
                op_idx++;
            end
        end
    end

    // Result monitor: every done pulse is checked against the next expected result.
    always @(negedge clk) begin
        logic [10:0] expv;
        cyc++;
        if (m_stop === 1'b1) stop_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            expv = (exp_done.size() > 0) ? exp_done.pop_front() : 11'h000;
            chk("done_result", 32'({1'b1, status, rdata}), 32'(expv));
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_req(input logic rd, input logic [AB-1:0] dev, input logic [7:0] rg, input logic [7:0] wd);
        req_read = rd;
        req_dev = dev;
        req_reg = rg;
        req_wdata = wd;
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = done_cnt;
        n = 0;
        while (done_cnt == start && n < budget) begin
            step();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - start), 32'd1);
    endtask

    initial begin
        int t0;
        int t1;
        int n;
        int d0;
        int s0;

        repeat (3) step();
        rst = 1'b0;
        step();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_status", 32'(status), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_cmds", 32'({m_start, m_stop, m_readNWrite, m_sendAck, m_dIn}), 32'd0);

        // Register write, all bytes ACKed
        exp_ops.push_back(op(1, 0, 0, 10'h050));
        exp_ops.push_back(op(0, 0, 0, 10'h012));
        exp_ops.push_back(op(0, 0, 0, 10'h0A5));
        exp_ops.push_back(op(0, 1, 0, 10'h000));
        exp_done.push_back({1'b1, 2'd0, exp_rdata});
        do_req(1'b0, 7'h50, 8'h12, 8'hA5);
        wait_done("wr", 200);
        step();
        chk("wr_ready_after_done", 32'(ready), 32'd1);
        chk("wr_done_one_cycle", 32'(done), 32'd0);

        // Register read with repeated START
        rbyte = 8'h5C;
        exp_rdata = 8'h5C;
        exp_ops.push_back(op(1, 0, 0, 10'h050));
        exp_ops.push_back(op(0, 0, 0, 10'h034));
        exp_ops.push_back(op(1, 0, 1, 10'h050));
        exp_ops.push_back(op(0, 0, 1, 10'h000));
        exp_ops.push_back(op(0, 1, 0, 10'h000));
        exp_done.push_back({1'b1, 2'd0, exp_rdata});
        do_req(1'b1, 7'h50, 8'h34, 8'h00);
        wait_done("rd", 200);
        step();

        // Address NACK on a read: STOP follows, rdata untouched
        rbyte = 8'hEE;
        nack_idx = 0;
        exp_ops.push_back(op(1, 0, 0, 10'h050));
        exp_ops.push_back(op(0, 1, 0, 10'h000));
        exp_done.push_back({1'b1, 2'd1, exp_rdata});
        do_req(1'b1, 7'h50, 8'h34, 8'h00);
        wait_done("addr_nack", 200);
        step();

        // Register-pointer NACK on a write
        nack_idx = 1;
        exp_ops.push_back(op(1, 0, 0, 10'h050));
        exp_ops.push_back(op(0, 0, 0, 10'h012));
        exp_ops.push_back(op(0, 1, 0, 10'h000));
        exp_done.push_back({1'b1, 2'd2, exp_rdata});
        do_req(1'b0, 7'h50, 8'h12, 8'hA5);
        wait_done("reg_nack", 200);
        step();
        nack_idx = -1;

        // Hung master: busy never rises after START
        hang = 1;
        s0 = stop_cnt;
        exp_done.push_back({1'b1, 2'd3, exp_rdata});
        do_req(1'b0, 7'h50, 8'h12, 8'hA5);
        chk("hang_start", 32'(m_start), 32'd1);
        t0 = cyc;
        n = 0;
        while (done !== 1'b1 && n < TO + 10) begin
            step();
            n++;
        end
        t1 = cyc;
        chk("hang_done_seen", 32'(done), 32'd1);
        chk("hang_latency", 32'(t1 - t0), 32'(TO + 2));
        chk("hang_no_stop", 32'(stop_cnt - s0), 32'd0);
        step();
        hang = 0;
        step();

        // Reset while the read byte is in flight
        rbyte = 8'h77;
        exp_ops.push_back(op(1, 0, 0, 10'h050));
        exp_ops.push_back(op(0, 0, 0, 10'h034));
        exp_ops.push_back(op(1, 0, 1, 10'h050));
        exp_ops.push_back(op(0, 0, 1, 10'h000));
        do_req(1'b1, 7'h50, 8'h34, 8'h00);
        n = 0;
        while (!(m_busy && cur_rd) && n < 200) begin
            step();
            n++;
        end
        chk("rdata_phase_reached", 32'(m_busy && cur_rd), 32'd1);
        d0 = done_cnt;
        mdl_hold = 1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_cmds", 32'({m_start, m_stop, m_readNWrite, m_sendAck, m_dIn}), 32'd0);
        chk("midrst_ready", 32'(ready), 32'd1);
        exp_rdata = 8'h00;
        step();
        mdl_hold = 0;
        repeat (3) step();
        chk("midrst_no_done", 32'(done_cnt), 32'(d0));
        chk("midrst_rdata_cleared", 32'(rdata), 32'd0);

        exp_ops.push_back(op(1, 0, 0, 10'h050));
        exp_ops.push_back(op(0, 0, 0, 10'h012));
        exp_ops.push_back(op(0, 0, 0, 10'h0A5));
        exp_ops.push_back(op(0, 1, 0, 10'h000));
        exp_done.push_back({1'b1, 2'd0, exp_rdata});
        do_req(1'b0, 7'h50, 8'h12, 8'hA5);
        wait_done("post_rst_wr", 200);
        step();

        // req held high: exactly two transactions, split by one ready cycle
        d0 = done_cnt;
        for (int k = 0; k < 2; k++) begin
            exp_ops.push_back(op(1, 0, 0, 10'h050));
            exp_ops.push_back(op(0, 0, 0, 10'h012));
            exp_ops.push_back(op(0, 0, 0, 10'h0A5));
            exp_ops.push_back(op(0, 1, 0, 10'h000));
            exp_done.push_back({1'b1, 2'd0, exp_rdata});
        end
        req_read = 1'b0;
        req_dev = 7'h50;
        req_reg = 8'h12;
        req_wdata = 8'hA5;
        req = 1'b1;
        wait_done("b2b_first", 200);
        step();
        chk("b2b_ready_gap", 32'(ready), 32'd1);
        step();
        chk("b2b_reaccept", 32'(ready), 32'd0);
        wait_done("b2b_second", 200);
        req = 1'b0;
        repeat (10) step();
        chk("b2b_count", 32'(done_cnt - d0), 32'd2);
        chk("b2b_idle", 32'(ready), 32'd1);

        chk("ops_drained", 32'(exp_ops.size()), 32'd0);
        chk("results_drained", 32'(exp_done.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
